// File: rtl/tis_pkg.sv
// Shared definitions for TIS-100 mesh nodes.
// Holds the default data width, the neighbour port index constants and the
// helper that sizes occupancy counters.
package tis_pkg;

  localparam int TIS_DATA_W = 11;

  localparam int UP    = 0;
  localparam int DOWN  = 1;
  localparam int LEFT  = 2;
  localparam int RIGHT = 3;

  // Width needed to hold values 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tis_stack_node_if.sv
// Neighbour bundle for tis_stack_node.
// in_data/in_valid/in_ready : push channel, port p at bits [p*DATA_W +: DATA_W]
// out_data/out_valid/out_ready : pop channel, out_data shared by all ports
// count : current stack occupancy
// master = neighbour side, slave = stack node side.
interface tis_stack_node_if
  import tis_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = TIS_DATA_W,
  parameter int DEPTH     = 15
);
  logic [NUM_PORTS*DATA_W-1:0] in_data;
  logic [NUM_PORTS-1:0]        in_valid;
  logic [NUM_PORTS-1:0]        in_ready;
  logic [DATA_W-1:0]           out_data;
  logic [NUM_PORTS-1:0]        out_valid;
  logic [NUM_PORTS-1:0]        out_ready;
  logic [cnt_w(DEPTH)-1:0]     count;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count
  );
endinterface

// File: rtl/tis_any_arbiter.sv
// ANY-style arbiter: request vector in, one-hot grant out, same cycle.
// Optional macro TIS_STACK_ROUND_ROBIN_EN: rotating priority pointer that
// moves to (granted port + 1) after each grant; otherwise lowest index wins.
// Ports: clk, reset (sync, active-high), req, grant.
// Callers gate req so that any grant is a completed transfer.
module tis_any_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant
);

`ifdef TIS_STACK_ROUND_ROBIN_EN
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic             hit;

  always_comb begin : rr_pick
    int k;
    grant    = '0;
    ptr_next = ptr;
    hit      = 1'b0;
    k        = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_PORTS) k = k - NUM_PORTS;
      if (!hit && req[k]) begin
        hit      = 1'b1;
        grant[k] = 1'b1;
        ptr_next = (k == NUM_PORTS - 1) ? '0 : PTR_W'(k + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (hit) ptr <= ptr_next;
  end
`else
  logic hit;
  logic unused_clk_reset;

  assign unused_clk_reset = clk ^ reset;

  always_comb begin
    grant = '0;
    hit   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!hit && req[i]) begin
        hit      = 1'b1;
        grant[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/tis_stack_node.sv
// Shared LIFO node for the TIS-100 mesh.
// Ports: clk, reset (sync, active-high), bus (tis_stack_node_if.slave).
// One push and one pop per cycle, each granted by a tis_any_arbiter.
// Optional macro TIS_STACK_ROUND_ROBIN_EN selects rotating priority in
// both arbiters; default build is fixed priority, lowest port wins.
module tis_stack_node
  import tis_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = TIS_DATA_W,
  parameter int DEPTH     = 15
) (
  input logic              clk,
  input logic              reset,
  tis_stack_node_if.slave  bus
);

  localparam int CNT_W  = cnt_w(DEPTH);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [CNT_W-1:0]     count_q;
  logic                 push_en;
  logic                 pop_en;
  logic [NUM_PORTS-1:0] push_grant;
  logic [NUM_PORTS-1:0] pop_grant;
  logic                 push;
  logic                 pop;
  logic [DATA_W-1:0]    push_data;
  logic [ADDR_W-1:0]    top_addr;
  logic [ADDR_W-1:0]    wr_addr;

  // Full blocks pushes even when a pop is granted in the same cycle.
  assign push_en = !reset && (count_q < CNT_W'(DEPTH));
  assign pop_en  = !reset && (count_q != '0);

  tis_any_arbiter #(.NUM_PORTS(NUM_PORTS)) u_push_arb (
    .clk   (clk),
    .reset (reset),
    .req   (bus.in_valid & {NUM_PORTS{push_en}}),
    .grant (push_grant)
  );

  tis_any_arbiter #(.NUM_PORTS(NUM_PORTS)) u_pop_arb (
    .clk   (clk),
    .reset (reset),
    .req   (bus.out_ready & {NUM_PORTS{pop_en}}),
    .grant (pop_grant)
  );

  assign push = |push_grant;
  assign pop  = |pop_grant;

  always_comb begin
    push_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push_grant[p]) push_data = bus.in_data[p*DATA_W +: DATA_W];
    end
  end

  assign top_addr = ADDR_W'(count_q - 1'b1);
  assign wr_addr  = ADDR_W'(count_q);

  // Push+pop replaces the top entry: popper sees the old value this cycle.
  always_ff @(posedge clk) begin
    if (push) mem[pop ? top_addr : wr_addr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else if (push && !pop) count_q <= count_q + 1'b1;
    else if (pop && !push) count_q <= count_q - 1'b1;
  end

  assign bus.out_data  = (count_q == '0) ? '0 : mem[top_addr];
  assign bus.in_ready  = push_grant;
  assign bus.out_valid = pop_grant;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_tis_stack_node.sv
module tb_tis_stack_node;
  import tis_pkg::*;

  localparam int NP    = 4;
  localparam int DW    = 11;
  localparam int DEPTH = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tis_stack_node_if #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEPTH)) bus ();

  tis_stack_node #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference: stack as a queue, top at the back.
  logic [DW-1:0] stk[$];
  int push_ptr = 0;
  int pop_ptr  = 0;

  logic [NP-1:0] cap_in_ready, cap_out_valid;
  logic [DW-1:0] cap_out_data;
  int            cap_count;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Highest-priority requester starting from 'start', circularly.
  function automatic int pick(input logic [NP-1:0] m, input int start);
    for (int i = 0; i < NP; i++) begin
      int k;
      k = (start + i) % NP;
      if (m[k]) return k;
    end
    return -1;
  endfunction

  task automatic set_push(input int port, input int val);
    bus.in_data[port*DW +: DW] = DW'(val);
  endtask

  // One clock: compare at negedge, advance model at posedge.
  task automatic cycle();
    int pu, po, ps, os;
    logic [NP-1:0] exp_ir, exp_ov;
    logic [DW-1:0] exp_od;
    @(negedge clk);
`ifdef TIS_STACK_ROUND_ROBIN_EN
    ps = push_ptr; os = pop_ptr;
`else
    ps = 0; os = 0;
`endif
    pu = -1; po = -1;
    if (!reset && stk.size() < DEPTH) pu = pick(bus.in_valid, ps);
    if (!reset && stk.size() > 0)     po = pick(bus.out_ready, os);
    exp_ir = '0; exp_ov = '0;
    if (pu >= 0) exp_ir[pu] = 1'b1;
    if (po >= 0) exp_ov[po] = 1'b1;
    exp_od = (stk.size() == 0) ? '0 : stk[$];
    cap_in_ready  = bus.in_ready;
    cap_out_valid = bus.out_valid;
    cap_out_data  = bus.out_data;
    cap_count     = int'(bus.count);
    check("in_ready",  32'(bus.in_ready),  32'(exp_ir));
    check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    check("out_data",  32'(bus.out_data),  32'(exp_od));
    check("count",     32'(bus.count),     32'(stk.size()));
    @(posedge clk);
    if (reset) begin
      stk.delete();
      push_ptr = 0;
      pop_ptr  = 0;
    end else begin
      if (pu >= 0 && po >= 0) stk[stk.size()-1] = bus.in_data[pu*DW +: DW];
      else if (pu >= 0)       stk.push_back(bus.in_data[pu*DW +: DW]);
      else if (po >= 0)       void'(stk.pop_back());
      if (pu >= 0) push_ptr = (pu + 1) % NP;
      if (po >= 0) pop_ptr  = (po + 1) % NP;
    end
    #1;
  endtask

  task automatic idle();
    bus.in_valid = '0; bus.out_ready = '0;
  endtask

  logic [NP-1:0] first_grant;

  initial begin
    reset = 1'b1;
    bus.in_data = '0; idle();
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    check("reset_count", 32'(cap_count), 32'd0);
    check("reset_out_data", 32'(cap_out_data), 32'd0);

    // Priority between two simultaneous pushers.
    set_push(LEFT, 5); bus.in_valid = 4'b0100; cycle();
    set_push(UP, 7); set_push(RIGHT, 7); bus.in_valid = 4'b1001; cycle();
    first_grant = cap_in_ready;
`ifdef TIS_STACK_ROUND_ROBIN_EN
    check("two_push_first", 32'(first_grant), 32'b1000);
`else
    check("two_push_first", 32'(first_grant), 32'b0001);
`endif
    bus.in_valid = bus.in_valid & ~first_grant; cycle();
    check("two_push_second", 32'(cap_in_ready), 32'(4'b1001 & ~first_grant));
    idle(); cycle();
    check("after_push_count", 32'(cap_count), 32'd3);
    check("after_push_top", 32'(cap_out_data), 32'd7);

    // Drain through DOWN.
    bus.out_ready = 4'b0010;
    cycle(); check("drain_pop1", 32'(cap_out_data), 32'd7);
    cycle(); check("drain_pop2", 32'(cap_out_data), 32'd7);
    cycle(); check("drain_pop3", 32'(cap_out_data), 32'd5);
    cycle();
    check("drain_empty_valid", 32'(cap_out_valid), 32'd0);
    check("drain_empty_count", 32'(cap_count), 32'd0);
    idle();

    // Fill to capacity.
    bus.in_valid = 4'b0001;
    for (int v = 1; v <= 15; v++) begin
      set_push(UP, v); cycle();
    end
    set_push(UP, 16); cycle();
    check("full_count", 32'(cap_count), 32'd15);
    check("full_no_ready", 32'(cap_in_ready), 32'd0);
    set_push(UP, 99); bus.out_ready = 4'b0010; cycle();
    check("full_pop_val", 32'(cap_out_data), 32'd15);
    check("full_push_stall", 32'(cap_in_ready), 32'd0);
    idle(); cycle();
    check("full_after_count", 32'(cap_count), 32'd14);
    check("full_after_top", 32'(cap_out_data), 32'd14);

    // Simultaneous push and pop when not full.
    reset = 1'b1; cycle(); reset = 1'b0;
    bus.in_valid = 4'b0001;
    set_push(UP, 3); cycle();
    set_push(UP, 4); cycle();
    idle();
    set_push(LEFT, 9); bus.in_valid = 4'b0100; bus.out_ready = 4'b0010; cycle();
    check("simul_pop_val", 32'(cap_out_data), 32'd4);
    idle(); cycle();
    check("simul_top", 32'(cap_out_data), 32'd9);
    check("simul_count", 32'(cap_count), 32'd2);

    // Everyone pushing at once.
    reset = 1'b1; cycle(); reset = 1'b0;
    for (int p = 0; p < NP; p++) set_push(p, 10 + p);
    bus.in_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      cycle();
`ifdef TIS_STACK_ROUND_ROBIN_EN
      check("all_push_grant", 32'(cap_in_ready), 32'(1 << (n % NP)));
`else
      check("all_push_grant", 32'(cap_in_ready), 32'd1);
`endif
    end
    idle(); cycle();
    check("all_push_count", 32'(cap_count), 32'd5);

    // Reset in the middle of traffic.
    set_push(UP, 42); bus.in_valid = 4'b0001; cycle();
    idle(); cycle();
    check("pre_reset_count", 32'(cap_count), 32'd6);
    reset = 1'b1; set_push(LEFT, 3); bus.in_valid = 4'b0100; bus.out_ready = 4'b1111; cycle();
    check("reset_in_ready", 32'(cap_in_ready), 32'd0);
    check("reset_out_valid", 32'(cap_out_valid), 32'd0);
    reset = 1'b0; bus.in_valid = '0; cycle();
    check("post_reset_count", 32'(cap_count), 32'd0);
    check("post_reset_valid", 32'(cap_out_valid), 32'd0);
    idle();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < NP; p++) set_push(p, int'($urandom));
      bus.in_valid  = NP'($urandom) & (($urandom_range(0, 3) == 0) ? 4'b0000 : 4'b1111);
      bus.out_ready = NP'($urandom) & (($urandom_range(0, 2) == 0) ? 4'b1111 : 4'b0000);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tis_stack_node.md
# tis_stack_node

Parametrised stack-memory node for the TIS-100 mesh. Any number of neighbouring compute nodes can push values onto a shared LIFO and pop from it. It replaces point-to-point node wiring wherever a node needs storage. Each port pair connects to one neighbour's directional port, and arbitration follows ANY semantics across all channels.

## Interface
Parameters:
- NUM_PORTS, 4: number of neighbour channels (index 0..NUM_PORTS-1; default order up, down, left, right).
- DATA_W, 11: signed data width, matching the node accumulator.
- DEPTH, 15: stack capacity in entries; must be at least 2.

Ports:
- clk  input  1  single clock. One clock; reset is synchronous and active-high.
- reset  input  1  synchronous, active-high reset.
- in_data  input  NUM_PORTS*DATA_W  push data; port p occupies bits [p*DATA_W +: DATA_W].
- in_valid  input  NUM_PORTS  neighbour p is offering a push.
- in_ready  output  NUM_PORTS  push from port p is accepted this cycle.
- out_data  output  DATA_W  current top of stack; shared by all ports.
- out_valid  output  NUM_PORTS  pop to port p is granted this cycle.
- out_ready  input  NUM_PORTS  neighbour p is requesting a pop.
- count  output  $clog2(DEPTH+1)  current occupancy.

## Operation
- Transfers: a push on port p occurs when in_valid[p] and in_ready[p] are both high. A pop on port p occurs when out_ready[p] and out_valid[p] are both high.
- Push arbitration: at most one push per cycle. The grant goes to the highest-priority requesting port, and only when count < DEPTH. No push is accepted while full, even if a pop occurs in the same cycle.
- Pop arbitration: at most one pop per cycle. The grant goes to the highest-priority port with out_ready high, and only when count > 0.
- in_ready and out_valid are combinational from in_valid/out_ready and the registered state. At most one bit of each vector is high per cycle.
- Push alone: mem[count] <= data; count increments.
- Pop alone: the popped value is out_data (mem[count-1]); count decrements.
- Push and pop in the same cycle:
  - The popper receives the old top.
  - mem[count-1] <= pushed data.
  - count is unchanged.
- Empty: all out_valid are 0. Full: all in_ready are 0.
- Arithmetic: data is stored unmodified. Widths are exact, with no saturation or sign manipulation.
- Reset:
  - count, and both priority pointers, go to 0.
  - in_ready and out_valid are forced to 0 while reset is high.
  - out_data is 0 while count == 0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards the stack. Any transfer attempted in that cycle does not occur.

## Timing
- A pushed value is visible on out_data the cycle after the push edge. There is no same-cycle pass-through from in_data to out_data.
- Pop latency is 0 cycles: out_data is valid during the granting cycle, and the neighbour samples it on that clk edge.
- A neighbour holds its request until granted. Requests may be dropped at any time without penalty.
- count updates on the clk edge following a transfer.

## Configuration
- TIS_STACK_ROUND_ROBIN_EN defined:
  - Push and pop arbiters each keep an independent rotating pointer.
  - After a grant to port p, the highest priority moves to port (p+1) mod NUM_PORTS.
  - A pointer only moves on a completed transfer.
- TIS_STACK_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins. No pointer registers exist.

## Structure
- Shared package tis_pkg holds:
  - the DATA_W default (11);
  - the port index constants UP=0, DOWN=1, LEFT=2, RIGHT=3;
  - the count-width helper function.
- One sub-module, tis_any_arbiter: parametrised NUM_PORTS request vector to one-hot grant, with the optional round-robin pointer. It is instantiated twice, once for push and once for pop.
- The storage array and count register live in tis_stack_node.

## Test plan
- Reset, then fixed priority: push 5 on port 2; next cycle push 7 on ports 0 and 3 simultaneously. Port 0 is granted first and port 3 one cycle later. Final state: count=3, out_data=7 (port 3's value).
- Drain: pop via port 1 three times. Values returned are 7, 7, 5. count reaches 0 and out_valid stays 0 with out_ready held high.
- Full: push 1..15 on port 0. count=15 and in_ready[0]=0 for a 16th push. A simultaneous push of 99 and pop in the full state: pop returns 15, the push stalls, count=14.
- Simultaneous, non-full: count=2 with top=4; push 9 and pop on different ports in one cycle. The popper gets 4, then out_data=9 and count=2.
- Round-robin (macro defined): all four ports hold in_valid with values 10..13. Grants arrive in order 0,1,2,3, then wrap to 0. Without the macro, port 0 wins every cycle.
- Reset mid-operation: with count=6, assert reset for 1 cycle while port 2 pushes 3. Result: count=0, all out_valid=0, and the push is not stored.
